diag_recip_unit: RTL



---
 rtl/diag_recip_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/diag_recip_unit.sv
// Diagonal reciprocal unit: turns a signed S7 diagonal coefficient into its
// S1.30 reciprocal (a_down) using a one-subtractor restoring divider.
//
// state | meaning
// IDLE  | waiting for a request; i_valid accepted here only
// DIV   | one quotient bit per cycle over dividend 2^FRAC, MSB first
// SIGN  | apply sign / divide-by-zero saturation, register the result
// DONE  | o_valid pulse, result stable
module diag_recip_unit #(
  parameter int DW   = 8,
  parameter int OW   = 32,
  parameter int FRAC = 30
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  input  logic [DW-1:0] i_diag,
  output logic          o_busy,
  output logic          o_valid,
  output logic [OW-1:0] o_a_down,
  output logic          o_div_zero
);

  localparam int QW = FRAC + 1;
  localparam int CW = $clog2(FRAC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAC);
  localparam logic [OW-1:0] SAT_POS = {1'b0, {(OW-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, DIV, SIGN, DONE} state_t;

  state_t        state, state_next;
  logic [DW:0]   rem_q;
  logic [QW-1:0] quo_q;
  logic [DW-1:0] div_q;
  logic          sign_q;
  logic [CW-1:0] cnt_q;
  logic [OW-1:0] a_down_q;
  logic          div_zero_q;

  logic          n_bit;
  logic [DW:0]   rem_shift;
  logic [DW:0]   rem_diff;
  logic          rem_ge;
  logic [DW-1:0] diag_abs;
  logic [OW-1:0] quo_ext;
  logic [OW-1:0] result;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_valid) state_next = DIV;
      DIV:  if (cnt_q == CNT_LAST) state_next = SIGN;
      SIGN: state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divider step, magnitude capture and sign/saturation of the result
  always_comb begin
    // The dividend 2^FRAC has a single set bit, consumed on the first iteration.
    n_bit     = (cnt_q == '0);
    rem_shift = {rem_q[DW-1:0], n_bit};
    // rem_q[DW] is the bit shifted out; if set, the true shifted value exceeds any divisor.
    rem_ge    = rem_q[DW] | (rem_shift >= {1'b0, div_q});
    rem_diff  = rem_shift - {1'b0, div_q};
    // Two's complement magnitude; -2^(DW-1) maps exactly onto the unsigned value 2^(DW-1).
    diag_abs  = i_diag[DW-1] ? (~i_diag + 1'b1) : i_diag;
    quo_ext   = OW'(quo_q);
    result    = sign_q ? (~quo_ext + 1'b1) : quo_ext;
    if (div_q == '0) result = SAT_POS;
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      sign_q     <= 1'b0;
      cnt_q      <= '0;
      a_down_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          sign_q <= i_diag[DW-1];
          div_q  <= diag_abs;
          rem_q  <= '0;
          quo_q  <= '0;
          cnt_q  <= '0;
        end
        DIV: begin
          rem_q <= rem_ge ? rem_diff : rem_shift;
          quo_q <= {quo_q[QW-2:0], rem_ge};
          cnt_q <= cnt_q + 1'b1;
        end
        SIGN: begin
          a_down_q   <= result;
          div_zero_q <= (div_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (state == DIV) || (state == SIGN);
  assign o_valid    = (state == DONE);
  assign o_a_down   = a_down_q;
  assign o_div_zero = div_zero_q;

endmodule
